// File: rtl/imm_ext_stage.sv
// Registered immediate-extension stage: extends an I-bit immediate to N bits
// by mode and queues results in a 2-entry skid buffer with valid/ready on both sides.
module imm_ext_stage #(
  parameter int N = 32,
  parameter int I = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [I-1:0] in_imm,
  input  logic [1:0]   in_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_y
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [N-1:0] head_q, head_d;
  logic [N-1:0] skid_q, skid_d;
  logic         in_ready_q, in_ready_d;

  logic [N-1:0] sext;
  logic [N-1:0] ext;
  logic         push;
  logic         pop;

  assign sext = {{(N-I){in_imm[I-1]}}, in_imm};

  // NOTE: every signal written in an always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    ext = sext;
    case (in_mode)
      2'd0:    ext = sext;
      2'd1:    ext = {{(N-I){1'b0}}, in_imm};
      2'd2:    ext = sext << 2;
      default: ext = {in_imm, {(N-I){1'b0}}};
    endcase
  end

  assign push      = in_valid && in_ready_q;
  assign pop       = out_valid && out_ready;
  assign out_valid = (state_q != EMPTY);
  assign out_y     = head_q;
  assign in_ready  = in_ready_q;

  // Results are stored already extended, so the mode never needs buffering.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = ONE;
          head_d  = ext;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_d = ext;
        end else if (push) begin
          state_d = TWO;
          skid_d  = ext;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          state_d = ONE;
          head_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    in_ready_d = (state_d != TWO);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values and simulation matches the synthesized netlist.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: head and skid are explicitly cleared because out_y must read
      // zero after reset; the data registers are not left uninitialised.
      state_q    <= EMPTY;
      head_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_imm_ext_stage.sv
// Directed-vector bench for imm_ext_stage: a 32-bit and a 64-bit instance share
// stimulus; expected values are hand-computed constants.
module tb_imm_ext_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic        out_ready;

  logic        in_ready, out_valid;
  logic [31:0] out_y;
  logic        in_ready64, out_valid64;
  logic [63:0] out_y64;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  imm_ext_stage #(.N(32), .I(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y)
  );

  imm_ext_stage #(.N(64), .I(16)) dut64 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready64),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .out_valid (out_valid64),
    .out_ready (out_ready),
    .out_y     (out_y64)
  );

  // Outputs are observed 1 time unit after the edge; inputs change there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    in_valid  = 1'b1;
    in_imm    = 16'h5555;
    in_mode   = 2'd0;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_vec++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_y !== 32'h0) begin
        n_err++;
        $display("FAIL reset_hold c%0d: in_ready=%b out_valid=%b out_y=%h, want 0 0 00000000",
                 c, in_ready, out_valid, out_y);
      end
    end
    n_vec++;
    if (out_y64 !== 64'h0 || in_ready64 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hold64: in_ready=%b out_y=%h, want 0 0", in_ready64, out_y64);
    end
    reset = 1'b1;
    step();
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, want 1 0 (held in_valid ignored)",
               in_ready, out_valid);
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_modes();
    logic [1:0]  modes[6] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd3};
    logic [15:0] imms[6]  = '{16'h8000, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h0001, 16'h1234};
    logic [31:0] exp32[6] = '{32'hFFFF8000, 32'h00007FFF, 32'h00008000,
                              32'hFFFFFFFC, 32'h00000004, 32'h12340000};
    logic [63:0] exp64[6] = '{64'hFFFFFFFF_FFFF8000, 64'h00000000_00007FFF,
                              64'h00000000_00008000, 64'hFFFFFFFF_FFFFFFFC,
                              64'h00000000_00000004, 64'h12340000_00000000};
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1;
      in_mode  = modes[k];
      in_imm   = imms[k];
      step();
      in_valid = 1'b0;
      n_vec++;
      if (out_valid !== 1'b1 || out_y !== exp32[k]) begin
        n_err++;
        $display("FAIL mode%0d_%h: out_valid=%b out_y=%h, want 1 %h",
                 modes[k], imms[k], out_valid, out_y, exp32[k]);
      end
      n_vec++;
      if (out_valid64 !== 1'b1 || out_y64 !== exp64[k]) begin
        n_err++;
        $display("FAIL n64_mode%0d_%h: out_valid=%b out_y=%h, want 1 %h",
                 modes[k], imms[k], out_valid64, out_y64, exp64[k]);
      end
      step();
      n_vec++;
      if (out_valid !== 1'b0 || out_y !== exp32[k]) begin
        n_err++;
        $display("FAIL drain_mode%0d: out_valid=%b out_y=%h, want 0 %h (retained)",
                 modes[k], out_valid, out_y, exp32[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 2'd1;
    in_imm    = 16'h0001;
    step();
    n_vec++;
    if (in_ready !== 1'b1 || out_y !== 32'h1) begin
      n_err++;
      $display("FAIL bp_first: in_ready=%b out_y=%h, want 1 00000001", in_ready, out_y);
    end
    in_imm = 16'h0002;
    step();
    n_vec++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_y !== 32'h1) begin
      n_err++;
      $display("FAIL bp_full: in_ready=%b out_valid=%b out_y=%h, want 0 1 00000001",
               in_ready, out_valid, out_y);
    end
    in_imm = 16'h0003;
    for (int c = 0; c < 2; c++) begin
      step();
      n_vec++;
      if (in_ready !== 1'b0 || out_y !== 32'h1) begin
        n_err++;
        $display("FAIL bp_stall c%0d: in_ready=%b out_y=%h, want 0 00000001", c, in_ready, out_y);
      end
    end
    out_ready = 1'b1;
    step();
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_y !== 32'h2) begin
      n_err++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b out_y=%h, want 1 1 00000002",
               in_ready, out_valid, out_y);
    end
    step();
    in_valid = 1'b0;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_y !== 32'h3) begin
      n_err++;
      $display("FAIL bp_third: in_ready=%b out_valid=%b out_y=%h, want 1 1 00000003",
               in_ready, out_valid, out_y);
    end
    step();
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_drain: out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  modes[4] = '{2'd0, 2'd1, 2'd2, 2'd3};
    logic [15:0] imms[4]  = '{16'hFFFE, 16'hABCD, 16'h8000, 16'hBEEF};
    logic [31:0] exp32[4] = '{32'hFFFFFFFE, 32'h0000ABCD, 32'hFFFE0000, 32'hBEEF0000};
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_mode  = modes[k];
      in_imm   = imms[k];
      step();
      n_vec++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_y !== exp32[k]) begin
        n_err++;
        $display("FAIL stream%0d: out_valid=%b in_ready=%b out_y=%h, want 1 1 %h",
                 k, out_valid, in_ready, out_y, exp32[k]);
      end
    end
    in_valid = 1'b0;
    step();
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stream_drain: out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 2'd1;
    in_imm    = 16'h0011;
    step();
    in_imm = 16'h0022;
    step();
    in_valid = 1'b0;
    n_vec++;
    if (in_ready !== 1'b0 || out_y !== 32'h11) begin
      n_err++;
      $display("FAIL mid_full: in_ready=%b out_y=%h, want 0 00000011", in_ready, out_y);
    end
    reset = 1'b0;
    step();
    n_vec++;
    if (out_valid !== 1'b0 || out_y !== 32'h0 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: out_valid=%b out_y=%h in_ready=%b, want 0 00000000 0",
               out_valid, out_y, in_ready);
    end
    reset     = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_vec++;
      if (out_valid !== 1'b0 || out_y !== 32'h0) begin
        n_err++;
        $display("FAIL mid_ghost c%0d: out_valid=%b out_y=%h, want 0 00000000", c, out_valid, out_y);
      end
    end
    in_valid = 1'b1;
    in_imm   = 16'h0033;
    step();
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b1 || out_y !== 32'h33) begin
      n_err++;
      $display("FAIL mid_after: out_valid=%b out_y=%h, want 1 00000033", out_valid, out_y);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_modes();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/imm_ext_stage.md
# imm_ext_stage

Registered, parametrised immediate-extension stage for the CPU datapath: takes an I-bit instruction immediate plus a mode code, and produces the N-bit extended operand. Modes: sign-extend, zero-extend, upper-load, or branch offset. A 2-entry skid buffer with valid/ready handshakes on both sides lets it sit between decode and execute without combinational ready paths. It supersedes the purely combinational sign extender, which is equivalent to mode 0 with the buffer removed.

## Interface
- N, default 32, output operand width; must satisfy N >= I+2 and N >= I.
- I, default 16, immediate width.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low; sampled on rising edge of clk.
- in_valid  in  1  producer has an immediate on in_imm/in_mode.
- in_ready  out  1  stage can accept this cycle; registered.
- in_imm  in  I  raw immediate.
- in_mode  in  2  0 = sign-extend, 1 = zero-extend, 2 = branch (sign-extend then shift left 2), 3 = upper (imm in bits N-1..N-I, lower N-I bits zero).
- out_valid  out  1  out_y holds a valid result.
- out_ready  in  1  consumer accepts out_y this cycle.
- out_y  out  N  extended result (head of buffer).

## Operation
- Extension is combinational on the input side. Results are stored already extended, so mode is not stored.
- Mode 0: replicate in_imm[I-1] into bits N-1..I.
- Mode 1: bits N-1..I are 0.
- Mode 2: mode-0 value shifted left 2, with bits 1..0 = 0. No bits are lost because N >= I+2.
- Mode 3: {in_imm, (N-I) zeros}.
- Push = in_valid && in_ready. Pop = out_valid && out_ready.
- Buffer FSM states: EMPTY, ONE, TWO. The head register drives out_y; the skid register holds the second entry.
  - EMPTY: push goes to ONE (head <= result).
  - ONE, push only: goes to TWO (skid <= result).
  - ONE, pop only: goes to EMPTY.
  - ONE, push and pop: stays ONE (head <= new result).
  - ONE, neither: holds.
  - TWO, pop: goes to ONE (head <= skid). Push is impossible in TWO because in_ready = 0.
  - TWO, no pop: holds.
- out_valid = (state != EMPTY).
- in_ready is registered as (next_state != TWO) && reset high.
- Ordering is strict FIFO; no entry is dropped or duplicated.
- While out_valid && !out_ready, out_y is stable.
- In EMPTY, out_y retains its last value; it is not cleared.

## Timing
- Reset (reset = 0 at an edge) sets state to EMPTY, out_valid = 0, out_y = 0 (head and skid cleared), in_ready = 0.
- in_ready rises at the first edge with reset = 1.
- Reset mid-operation discards all buffered entries at that edge, regardless of in_valid or out_ready.
- Latency is 1 cycle: a push at edge k gives out_valid = 1 with the result on out_y after edge k, when entering from EMPTY.
- Throughput is 1 result per cycle when out_ready stays high.
- Full boundary: the edge that enters TWO drops in_ready in the same update. The first pop from TWO re-raises in_ready after that edge. There is one idle input cycle after a full-stall release.
- Simultaneous push and pop in ONE keeps occupancy at 1 and in_ready at 1.
- Inputs in_imm/in_mode are don't-care when in_valid = 0. in_valid while in_ready = 0 is ignored; the producer must hold.

## Test plan
- Reset: hold reset = 0 for 3 cycles with in_valid = 1 -> in_ready = 0, out_valid = 0, out_y = 0. After release, in_ready = 1 on the next cycle.
- Sign/zero (N=32, I=16), each pushed with out_ready = 1:
  - mode 0, 0x8000 -> out_y = 0xFFFF8000 one cycle later.
  - mode 0, 0x7FFF -> 0x00007FFF.
  - mode 1, 0x8000 -> 0x00008000.
- Branch/upper:
  - mode 2, 0xFFFF -> 0xFFFFFFFC.
  - mode 2, 0x0001 -> 0x00000004.
  - mode 3, 0x1234 -> 0x12340000.
  - N=64 build, mode 0, 0x8000 -> 0xFFFFFFFFFFFF8000.
- Backpressure: out_ready = 0, push 0x0001 then 0x0002 (mode 1).
  - in_ready = 0 after the second push; out_y holds 0x00000001.
  - A third in_valid is held and not accepted.
  - Raise out_ready -> out_y = 0x1, then 0x2, then the third, in order, with no loss.
- Streaming: out_ready = 1, push 4 back-to-back immediates, mixed modes -> 4 results on 4 consecutive cycles, in_ready stays 1, state never reaches TWO.
- Reset mid-operation: fill to TWO, assert reset = 0 for one edge -> out_valid = 0, out_y = 0, in_ready = 0. After release, the old entries never reappear.
